// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: two-requester round-robin write arbiter for a register bank with a zeroing sweep
// Ports:
//   clk, reset (async active-low)
//   clear                         request a zeroing sweep of all 2**ADDR_W registers
//   req0_valid/addr/data, req0_ready   requester 0 write request and accept
//   req1_valid/addr/data, req1_ready   requester 1 write request and accept
//   bank_write, bank_dr, bank_write_data  registered bank write port (one-cycle latency)
//   busy                          high while the sweep runs
//   last_grant                    id of the most recently accepted requester
// Macro ARB_CLEAR_ON_RESET_EN: reset parks the block in CLEAR so a full sweep follows release.
module reg_bank_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              bank_write,
  output logic [ADDR_W-1:0] bank_dr,
  output logic [DATA_W-1:0] bank_write_data,
  output logic              busy,
  output logic              last_grant
);
  typedef enum logic {ARB, CLEAR} state_t;
`ifdef ARB_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = ARB;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, dr_q, dr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic last_q, last_d, bw_q, bw_d;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    bw_d       = 1'b0;
    dr_d       = dr_q;
    wd_d       = wd_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b0;
    if (state_q == CLEAR) begin
      busy  = 1'b1;
      bw_d  = 1'b1;
      dr_d  = cnt_q;
      wd_d  = '0;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == '1) ? ARB : CLEAR;
    end else if (clear) begin
      state_d = CLEAR;
    end else begin
      // on a tie the requester that did not win last time is served
      req0_ready = req0_valid & (~req1_valid | last_q);
      req1_ready = req1_valid & (~req0_valid | ~last_q);
      if (req0_ready) begin
        bw_d   = 1'b1;
        dr_d   = req0_addr;
        wd_d   = req0_data;
        last_d = 1'b0;
      end else if (req1_ready) begin
        bw_d   = 1'b1;
        dr_d   = req1_addr;
        wd_d   = req1_data;
        last_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      bw_q    <= 1'b0;
      dr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bw_q    <= bw_d;
      dr_q    <= dr_d;
      wd_q    <= wd_d;
    end
  end
  assign bank_write      = bw_q;
  assign bank_dr         = dr_q;
  assign bank_write_data = wd_q;
  assign last_grant      = last_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: randomized and directed check of reg_bank_arbiter against a transaction-level model
module tb_reg_bank_arbiter;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, bank_write, busy, last_grant;
  logic [4:0] bank_dr;
  logic [31:0] bank_write_data;
  int errors = 0, checks = 0;
  int sweep, last;
  logic e_bw;
  logic [4:0] e_dr;
  logic [31:0] e_wd;

  reg_bank_arbiter dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .bank_write(bank_write), .bank_dr(bank_dr), .bank_write_data(bank_write_data),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

`ifdef ARB_CLEAR_ON_RESET_EN
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_BEEF;
  always @(posedge clk) if (bank_write) mem[bank_dr] <= bank_write_data;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    last = 1;
    e_bw = 1'b0;
    e_dr = '0;
    e_wd = '0;
`ifdef ARB_CLEAR_ON_RESET_EN
    sweep = 0;
`else
    sweep = -1;
`endif
  endtask

  // called at a negedge with reset currently high or low; leaves reset low for one posedge
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_bank_write", {31'd0, bank_write}, 32'd0);
    chk("rst_bank_dr", {27'd0, bank_dr}, 32'd0);
    chk("rst_bank_data", bank_write_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, {31'd0, sweep >= 0});
    chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic clr);
    int g;
    chk("bank_write", {31'd0, bank_write}, {31'd0, e_bw});
    chk("bank_dr", {27'd0, bank_dr}, {27'd0, e_dr});
    chk("bank_data", bank_write_data, e_wd);
    chk("busy", {31'd0, busy}, {31'd0, sweep >= 0});
    chk("last_grant", {31'd0, last_grant}, last[31:0]);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear = clr;
    #1;
    g = -1;
    if (sweep < 0 && !clr) g = (v0 && v1) ? 1 - last : v0 ? 0 : v1 ? 1 : -1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    if (sweep >= 0) begin
      e_bw = 1'b1; e_dr = sweep[4:0]; e_wd = '0;
      sweep = (sweep == 31) ? -1 : sweep + 1;
    end else if (clr) begin
      e_bw = 1'b0; sweep = 0;
    end else if (g >= 0) begin
      e_bw = 1'b1; e_dr = g ? a1 : a0; e_wd = g ? d1 : d0; last = g;
    end else e_bw = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
`ifdef ARB_CLEAR_ON_RESET_EN
    repeat (33) step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) chk("readback", mem[i], 32'd0);
`endif
    step(1, 5, 50, 0, 0, 0, 0);
    chk("single_dr", {27'd0, bank_dr}, 32'd5);
    chk("single_data", bank_write_data, 32'd50);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
`ifdef ARB_CLEAR_ON_RESET_EN
    repeat (33) step(0, 0, 0, 0, 0, 0, 0);
`endif
    repeat (4) step(1, 1, 10, 1, 2, 20, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 20, 1);
    repeat (33) step(0, 0, 0, 1, 2, 20, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    while (sweep != 10) step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 1) == 1, 5'($urandom), $urandom, $urandom_range(0, 1) == 1,
           5'($urandom), $urandom, $urandom_range(0, 39) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
